// File: rtl/salsa_sched.sv
// -----------------------------------------------------------------------------
// salsa_sched
//
// Front-end scheduler for a 9-stage registered salsa20/8 core. A 9-slot
// time-division ring matches the core's 9-cycle recirculation latency, so the
// slot that is being visited always lines up with the job the core is about
// to hand back on its feedback path.
//
// Each job is presented to the core four times: one fresh injection
// (feedback=0), then three feedback passes (feedback=1). The job's B/Bx are
// re-presented on every pass because the core forms its final sum from the
// B/Bx it sees on the last pass.
//
// The final Bo (and, optionally, the core's next scratchpad address) is
// captured and returned with the job's tag as a one-cycle strobe. There is
// no backpressure on the result side.
//
// Configuration macro:
//   SALSA_SCHED_XADDR_EN  when defined, salsa_Xaddr is sampled one cycle
//                         before Bo and returned on out_addr. When undefined,
//                         out_addr is constant 0 and salsa_Xaddr is ignored.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        job offered
//   in_ready        job accepted on this edge when in_valid & in_ready
//   in_B, in_Bx     BlockMix halves X0 / X1 (512 bits each)
//   in_tag          job identifier (TAG_W bits)
//   salsa_B         registered B to core
//   salsa_Bx        registered Bx to core
//   salsa_feedback  registered core feedback select
//   salsa_Bo        core final sum
//   salsa_Xaddr     core address output
//   out_valid       one-cycle result strobe
//   out_Bo          salsa20/8 result
//   out_addr        next scratchpad index
//   out_tag         tag of result
// -----------------------------------------------------------------------------
module salsa_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_B,
    input  logic [511:0]     in_Bx,
    input  logic [TAG_W-1:0] in_tag,
    output logic [511:0]     salsa_B,
    output logic [511:0]     salsa_Bx,
    output logic             salsa_feedback,
    input  logic [511:0]     salsa_Bo,
    input  logic [9:0]       salsa_Xaddr,
    output logic             out_valid,
    output logic [511:0]     out_Bo,
    output logic [9:0]       out_addr,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SLOTS = 9;
    localparam int MK_D  = 8;

    // Ring position and per-slot control state
    logic [3:0]       ptr;
    logic [SLOTS-1:0] busy;
    logic [1:0]       pass_q [SLOTS];

    // Per-slot job data (not reset: only meaningful while the slot is busy)
    logic [TAG_W-1:0] tag_q [SLOTS];
    logic [511:0]     b_q   [SLOTS];
    logic [511:0]     bx_q  [SLOTS];

    // Last-pass marker that travels with the presentation registers, then
    // an 8-deep marker pipe behind it. mk_vld[MK_D-1] is high during the
    // cycle in which the core's final sum for that job is on salsa_Bo.
    logic             last_p0;
    logic [TAG_W-1:0] last_tag_p0;
    logic [MK_D-1:0]  mk_vld;
    logic [TAG_W-1:0] mk_tag [MK_D];

    logic accept;

    assign in_ready = rst_n & ~busy[ptr];
    assign accept   = in_valid & in_ready;

    // Job store: written only on accept into the slot being visited
    always_ff @(posedge clk) begin
        if (accept) begin
            b_q[ptr]   <= in_B;
            bx_q[ptr]  <= in_Bx;
            tag_q[ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= '0;
            busy           <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                pass_q[k] <= 2'd0;
            end
            salsa_B        <= '0;
            salsa_Bx       <= '0;
            salsa_feedback <= 1'b0;
            last_p0        <= 1'b0;
            last_tag_p0    <= '0;
            mk_vld         <= '0;
            for (int j = 0; j < MK_D; j++) begin
                mk_tag[j] <= '0;
            end
            out_valid      <= 1'b0;
            out_Bo         <= '0;
            out_tag        <= '0;
        end else begin
            ptr <= (ptr == 4'(SLOTS - 1)) ? 4'd0 : ptr + 4'd1;

            // Presentation stage: decide what slot ptr shows the core next cycle
            last_p0     <= 1'b0;
            last_tag_p0 <= tag_q[ptr];
            if (accept) begin
                busy[ptr]      <= 1'b1;
                pass_q[ptr]    <= 2'd1;
                salsa_B        <= in_B;
                salsa_Bx       <= in_Bx;
                salsa_feedback <= 1'b0;
            end else if (busy[ptr]) begin
                salsa_B        <= b_q[ptr];
                salsa_Bx       <= bx_q[ptr];
                salsa_feedback <= 1'b1;
                if (pass_q[ptr] == 2'd3) begin
                    // Final pass: slot frees up for its next visit
                    busy[ptr] <= 1'b0;
                    last_p0   <= 1'b1;
                end else begin
                    pass_q[ptr] <= pass_q[ptr] + 2'd1;
                end
            end else begin
                salsa_B        <= '0;
                salsa_Bx       <= '0;
                salsa_feedback <= 1'b0;
            end

            // Marker pipe: follows the job through the core's latency
            mk_vld    <= {mk_vld[MK_D-2:0], last_p0};
            mk_tag[0] <= last_tag_p0;
            for (int j = 1; j < MK_D; j++) begin
                mk_tag[j] <= mk_tag[j-1];
            end

            // Result capture: Bo is valid while the marker sits at the tail
            out_valid <= mk_vld[MK_D-1];
            if (mk_vld[MK_D-1]) begin
                out_Bo  <= salsa_Bo;
                out_tag <= mk_tag[MK_D-1];
            end
        end
    end

`ifdef SALSA_SCHED_XADDR_EN
    // The core's address output leads its final sum by one cycle, so it is
    // sampled one cycle early and released together with Bo.
    logic [9:0] addr_p7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p7  <= '0;
            out_addr <= '0;
        end else begin
            addr_p7 <= salsa_Xaddr;
            if (mk_vld[MK_D-1]) begin
                out_addr <= addr_p7;
            end
        end
    end
`else
    logic unused_xaddr;

    assign unused_xaddr = ^salsa_Xaddr;
    assign out_addr     = '0;
`endif

endmodule

// File: doc/salsa_sched.md
# salsa_sched

Front-end scheduler for the 9-stage registered salsa20/8 pipeline. Owns a 9-slot time-division ring matching the core's 9-cycle recirculation latency. Accepts independent (B, Bx) jobs and drives the core's B/Bx/feedback inputs: one fresh injection, then three feedback passes per job, re-presenting the job's B/Bx on every pass so the core's delayed final sum is correct. Captures the final Bo and next scratchpad address and returns them tagged.

## Interface
- TAG_W, 4: width of the job tag returned with each result.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted on this edge when in_valid & in_ready.
- in_B  in  512  BlockMix half X0.
- in_Bx  in  512  BlockMix half X1.
- in_tag  in  TAG_W  job identifier.
- salsa_B  out  512  registered B to core.
- salsa_Bx  out  512  registered Bx to core.
- salsa_feedback  out  1  registered core feedback select.
- salsa_Bo  in  512  core final sum.
- salsa_Xaddr  in  10  core address output.
- out_valid  out  1  one-cycle result strobe; no backpressure.
- out_Bo  out  512  salsa20/8 result.
- out_addr  out  10  next scratchpad index.
- out_tag  out  TAG_W  tag of result.

## Operation
- ptr: 0..8 counter, +1 every clock, 8 wraps to 0.
- Per slot k: busy, pass[1:0], tag, B, Bx, held in a 9-entry store.
- in_ready = rst_n & !busy[ptr].
- Each cycle with ptr=k, the salsa_* registers load slot k's presentation for the next cycle (P):
  - Accept (in_valid & in_ready): store B, Bx, tag. Set busy, pass=1. Present in_B, in_Bx, feedback=0.
  - Busy, pass in 1..2: present stored B, Bx, feedback=1, then pass++.
  - Busy, pass=3: present stored B, Bx, feedback=1. Clear busy. Push {1, tag} into an 8-deep marker pipe.
  - Free, no accept: present B=Bx=0, feedback=0 (bubble). Push {0, x}.
- Marker pipe taps:
  - At P+7: sample salsa_Xaddr into an address pipe.
  - At P+8, marker valid: register out_Bo<=salsa_Bo, out_addr, out_tag. out_valid high during P+9.
- No result is ever dropped or stalled. The downstream block must sink every out_valid.

## Timing
- Reset values: ptr=0; all busy=0; salsa_B=salsa_Bx=0; salsa_feedback=0; marker pipe 0; out_valid=0; out_Bo=0; out_addr=0; out_tag=0.
- Accept edge ends cycle A. Pass 0 presented at A+1, then passes at A+10, A+19, A+28. out_valid during A+37.
- Throughput: up to 9 jobs in flight; at most one accept per cycle; sustained 9 results per 36 cycles.
- A slot is free again on its next visit after pass 3. Result emergence and a new accept into the same slot may coincide; both proceed independently.
- Consecutive accepts occupy consecutive slots. Results emerge in accept order, one per cycle.
- Reset mid-operation discards all in-flight jobs; no out_valid is produced for them.

## Configuration
- SALSA_SCHED_XADDR_EN defined: the address pipe is built and out_addr carries the sampled salsa_Xaddr.
- Not defined: the address pipe is omitted, out_addr is constant 0, and salsa_Xaddr is ignored.

## Test plan
- Single job: B word0=0x1, Bx=0, tag=3, accepted at cycle 5.
  - salsa_feedback=0 at cycle 6 and =1 at 15/24/33.
  - out_valid only at cycle 42, tag=3, out_Bo equal to the C-model salsa20/8 of (B, Bx).
- Back-to-back 9 jobs, tags 0..8, in_valid held:
  - in_ready high for 9 cycles, then low for 27 cycles.
  - 9 consecutive out_valid pulses, tags 0..8 in order, each matching the model.
- Continuous in_valid for 200 cycles:
  - A new accept into a freed slot lands in the same cycle as that slot's result emergence.
  - No lost or duplicated tags; accept count equals result count after drain.
- Assert rst_n low at cycle 20 with 4 jobs in flight:
  - All outputs return to reset values asynchronously.
  - No out_valid afterwards; in_ready=1 on the first cycle after release.
- SALSA_SCHED_XADDR_EN on: out_addr equals (model Bo word0)[9:0]. Off: out_addr stays 0 throughout.
